// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle execute-stage ALU.
// Single-cycle logic/arith/compare ops, bit-serial shifter.
module alu_seq_exec #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADDM = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0111;
    localparam logic [3:0] OP_NE   = 4'b1000;
    localparam logic [3:0] OP_LT   = 4'b1001;
    localparam logic [3:0] OP_GE   = 4'b1010;
    localparam logic [3:0] OP_LTU  = 4'b1011;
    localparam logic [3:0] OP_GEU  = 4'b1100;
    localparam logic [3:0] OP_SLL  = 4'b1101;
    localparam logic [3:0] OP_SRA  = 4'b1110;
    localparam logic [3:0] OP_SRL  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sreg, sreg_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [SHW-1:0]   cnt, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] alu_comb;
    logic [WIDTH-1:0] shifted;
    logic             cond;
    logic             is_cmp;
    logic             is_shift;
    logic [SHW-1:0]   shamt;

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign shamt     = SrcB[SHW-1:0];
    assign is_shift  = (Operation == OP_SLL) ||
                       (Operation == OP_SRL) ||
                       (Operation == OP_SRA);

    // Single-cycle datapath for logic, arithmetic and compare ops
    always_comb begin
        alu_comb = '0;
        cond     = 1'b0;
        is_cmp   = 1'b0;
        case (Operation)
            OP_AND:  alu_comb = SrcA & SrcB;
            OP_OR:   alu_comb = SrcA | SrcB;
            OP_ADD:  alu_comb = SrcA + SrcB;
            OP_XOR:  alu_comb = SrcA ^ SrcB;
            OP_ADDM: alu_comb = SrcA + SrcB;
            OP_SUB:  alu_comb = SrcA - SrcB;
            OP_EQ: begin
                is_cmp = 1'b1;
                cond   = (SrcA == SrcB);
            end
            OP_NE: begin
                is_cmp = 1'b1;
                cond   = (SrcA != SrcB);
            end
            OP_LT: begin
                is_cmp = 1'b1;
                cond   = ($signed(SrcA) < $signed(SrcB));
            end
            OP_GE: begin
                is_cmp = 1'b1;
                cond   = ($signed(SrcA) >= $signed(SrcB));
            end
            OP_LTU: begin
                is_cmp = 1'b1;
                cond   = (SrcA < SrcB);
            end
            OP_GEU: begin
                is_cmp = 1'b1;
                cond   = (SrcA >= SrcB);
            end
            default: alu_comb = '0;
        endcase
        if (is_cmp) begin
            alu_comb = {{(WIDTH-1){1'b0}}, cond};
        end
    end

    // One-bit step of the iterative shifter; SRA replicates the MSB
    always_comb begin
        case (op_q)
            OP_SLL:  shifted = {sreg[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, sreg[WIDTH-1:1]};
            default: shifted = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
        endcase
    end

    // Next-state and next-register logic
    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        cnt_d   = cnt;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift) begin
                        sreg_d = SrcA;
                        cnt_d  = shamt;
                        op_d   = Operation;
                        if (shamt == '0) begin
                            res_d   = SrcA;
                            zero_d  = (SrcA == '0);
                            state_d = DONE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        res_d   = alu_comb;
                        zero_d  = is_cmp ? cond : (alu_comb == '0);
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                sreg_d = shifted;
                cnt_d  = cnt - 1'b1;
                if (cnt == SHW'(1)) begin
                    res_d   = shifted;
                    zero_d  = (shifted == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            op_q   <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            state  <= state_d;
            sreg   <= sreg_d;
            cnt    <= cnt_d;
            op_q   <= op_d;
            res_q  <= res_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed + random checks of alu_seq_exec
// against a plain-arithmetic reference model.
module tb_alu_seq_exec;

    localparam logic [3:0] AND_ = 4'b0000;
    localparam logic [3:0] ADD_ = 4'b0010;
    localparam logic [3:0] XOR_ = 4'b0011;
    localparam logic [3:0] SUB_ = 4'b0110;
    localparam logic [3:0] LT_  = 4'b1001;
    localparam logic [3:0] LTU_ = 4'b1011;
    localparam logic [3:0] GEU_ = 4'b1100;
    localparam logic [3:0] SLL_ = 4'b1101;
    localparam logic [3:0] SRA_ = 4'b1110;
    localparam logic [3:0] SRL_ = 4'b1111;
    localparam logic [3:0] ILL_ = 4'b0101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;

    int checks = 0;
    int errors = 0;

    alu_seq_exec #(.WIDTH(32), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: what each op means, with its accept->out_valid latency
    task automatic model(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output logic [31:0] r,
                         output logic z,
                         output int lat);
        int n;
        bit c;
        bit cmp;
        n   = int'(b[4:0]);
        lat = 1;
        cmp = 1'b0;
        c   = 1'b0;
        r   = 32'h0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a ^ b;
            4'd4:  r = a + b;
            4'd6:  r = a - b;
            4'd7:  begin cmp = 1; c = (a == b); end
            4'd8:  begin cmp = 1; c = (a != b); end
            4'd9:  begin cmp = 1; c = ($signed(a) < $signed(b)); end
            4'd10: begin cmp = 1; c = ($signed(a) >= $signed(b)); end
            4'd11: begin cmp = 1; c = (a < b); end
            4'd12: begin cmp = 1; c = (a >= b); end
            4'd13: begin r = a << n; lat = n + 1; end
            4'd14: begin r = $signed(a) >>> n; lat = n + 1; end
            4'd15: begin r = a >> n; lat = n + 1; end
            default: r = 32'h0;
        endcase
        if (cmp) begin
            r = {31'h0, c};
            z = c;
        end else begin
            z = (r == 32'h0);
        end
    endtask

    // One full transaction; hold = cycles of out_ready low after out_valid
    task automatic run_op(input logic [3:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input int hold);
        logic [31:0] er;
        logic        ez;
        int          el;
        int          lat;
        model(op, a, b, er, ez, el);
        @(negedge clk);
        check("in_ready_idle", {31'h0, in_ready}, 32'h1);
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        out_ready = (hold == 0);
        @(negedge clk);
        lat       = 1;
        in_valid  = (hold != 0);
        Operation = 4'($urandom_range(0, 15));
        SrcA      = $urandom;
        SrcB      = $urandom;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, el);
        check("result", ALUResult, er);
        check("zero", {31'h0, Zero}, {31'h0, ez});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'h0, out_valid}, 32'h1);
            check("hold_result", ALUResult, er);
            check("hold_zero", {31'h0, Zero}, {31'h0, ez});
            check("hold_in_ready", {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("drop_valid", {31'h0, out_valid}, 32'h0);
        check("ready_again", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        Operation = 4'h0;
        SrcA      = 32'h0;
        SrcB      = 32'h0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_result", ALUResult, 32'h0);
        check("rst_zero", {31'h0, Zero}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        rst_n = 1'b1;

        run_op(ADD_, 32'd5, 32'd7, 0);
        check("add_val", ALUResult, 32'd12);
        run_op(SUB_, 32'd7, 32'd7, 0);
        check("sub_zero", {31'h0, Zero}, 32'h1);
        run_op(LT_, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(LTU_, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(GEU_, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(SRA_, 32'h8000_0000, 32'd4, 0);
        check("sra_val", ALUResult, 32'hF800_0000);
        run_op(SRL_, 32'h8000_0000, 32'd4, 0);
        run_op(SLL_, 32'h8000_0000, 32'd0, 0);
        run_op(SLL_, 32'h0000_0001, 32'd31, 0);
        run_op(ILL_, 32'h1234_5678, 32'h9, 0);
        run_op(AND_, 32'hF0F0, 32'h0F0F, 1);
        run_op(XOR_, 32'hF0F0, 32'h0FF0, 3);
        check("xor_val", ALUResult, 32'hFF00);

        // abort an SLL by 10 during its third cycle
        @(negedge clk);
        in_valid  = 1'b1;
        Operation = SLL_;
        SrcA      = 32'h3;
        SrcB      = 32'd10;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_valid", {31'h0, out_valid}, 32'h0);
        check("abort_result", ALUResult, 32'h0);
        check("abort_zero", {31'h0, Zero}, 32'h0);
        check("abort_in_ready", {31'h0, in_ready}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", {31'h0, in_ready}, 32'h1);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("aborted_no_valid", seen, 0);
        run_op(ADD_, 32'd1, 32'd1, 0);
        check("add_after_abort", ALUResult, 32'd2);

        for (int k = 0; k < 60; k++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) == 1, 31'h0};
            run_op(op, a, b, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
